// File: rtl/grant16_encode.sv
// grant16_encode: turns a winning requester index into a registered one-hot grant,
// holds it until done/withdrawn/hold-limit, then inserts a one-cycle bubble.
module grant16_encode #(
    parameter int   DWIDTH   = 16,
    parameter logic TARGET   = 1'b1,
    parameter int   MAX_HOLD = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_sel_vld,
    input  logic [$clog2(DWIDTH)-1:0] i_sel,
    input  logic [DWIDTH-1:0]         i_req,
    input  logic                      i_done,
    output logic                      o_ready,
    output logic [DWIDTH-1:0]         o_grant,
    output logic                      o_grant_vld,
    output logic [$clog2(DWIDTH)-1:0] o_grant_idx,
    output logic                      o_timeout
);
    localparam int IW = $clog2(DWIDTH);
    // A disabled limit would give a zero-width counter, so keep at least one bit.
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [DWIDTH-1:0] OFF = {DWIDTH{~TARGET}};

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              to_q, to_d;
    logic [DWIDTH-1:0] onehot;
    logic              sel_ok, accept, req_cur, hit_lim, release_now;

    assign onehot      = {{(DWIDTH-1){1'b0}}, 1'b1} << i_sel;
    assign sel_ok      = 32'(i_sel) < 32'(DWIDTH);
    assign accept      = (state_q == IDLE) && i_sel_vld && sel_ok && i_req[i_sel];
    assign req_cur     = i_req[idx_q];
    assign hit_lim     = (MAX_HOLD != 0) && (cnt_q == LIM);
    assign release_now = i_done || !req_cur || hit_lim;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = GRANT;
                    grant_d = TARGET ? onehot : ~onehot;
                    idx_d   = i_sel;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (release_now) begin
                    state_d = GAP;
                    grant_d = OFF;
                    vld_d   = 1'b0;
                    // Timeout only reported when neither done nor withdrawal caused the exit.
                    to_d    = !i_done && req_cur && hit_lim;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_grant     = grant_q;
    assign o_grant_vld = vld_q;
    assign o_grant_idx = idx_q;
    assign o_timeout   = to_q;
endmodule

// File: tb/tb_grant16_encode.sv
// tb_grant16_encode: directed bench driving two encoders in parallel,
// one active-high with MAX_HOLD=4 and one active-low with the hold limit disabled.
module tb_grant16_encode;
    logic        clk = 1'b0;
    logic        rst, sel_vld, done;
    logic [3:0]  sel;
    logic [15:0] req;
    logic        rp, vp, tp, rn, vn, tn;
    logic [15:0] gp, gn;
    logic [3:0]  ip, in_;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    grant16_encode #(.DWIDTH(16), .TARGET(1'b1), .MAX_HOLD(4)) u_p (
        .i_clk(clk), .i_rst(rst), .i_sel_vld(sel_vld), .i_sel(sel), .i_req(req), .i_done(done),
        .o_ready(rp), .o_grant(gp), .o_grant_vld(vp), .o_grant_idx(ip), .o_timeout(tp));

    grant16_encode #(.DWIDTH(16), .TARGET(1'b0), .MAX_HOLD(0)) u_n (
        .i_clk(clk), .i_rst(rst), .i_sel_vld(sel_vld), .i_sel(sel), .i_req(req), .i_done(done),
        .o_ready(rn), .o_grant(gn), .o_grant_vld(vn), .o_grant_idx(in_), .o_timeout(tn));

    always @(negedge clk) begin
        n_assert++;
        if ($countones(gp) > 1 || $countones(~gn) > 1) begin
            n_fail++;
            $display("FAIL onehot t=%0t gp=%h gn=%h", $time, gp, gn);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {grant, vld, idx, timeout, ready}
    task automatic test_reset();
        rst = 1'b1; sel_vld = 1'b1; sel = 4'd5; req = 16'hFFFF; done = 1'b0;
        step();
        step();
        rst = 1'b0; sel_vld = 1'b0;
        n_assert++;
        if ({gp, vp, ip, tp, rp} !== {16'h0000, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_p got %h/%b/%0d/%b/%b", gp, vp, ip, tp, rp);
        end
        n_assert++;
        if ({gn, vn, in_, tn, rn} !== {16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_n got %h/%b/%0d/%b/%b", gn, vn, in_, tn, rn);
        end
    endtask

    task automatic test_basic();
        sel_vld = 1'b1; sel = 4'd5; req = 16'h0020;
        step();
        sel_vld = 1'b0;
        n_assert++;
        if ({gp, vp, ip, rp} !== {16'h0020, 1'b1, 4'd5, 1'b0}) begin
            n_fail++; $display("FAIL basic_grant_p got %h/%b/%0d/%b", gp, vp, ip, rp);
        end
        n_assert++;
        if ({gn, vn, in_} !== {16'hFFDF, 1'b1, 4'd5}) begin
            n_fail++; $display("FAIL basic_grant_n got %h/%b/%0d", gn, vn, in_);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_assert++;
        if ({gp, vp, rp, tp, ip, gn, vn} !== {16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'hFFFF, 1'b0}) begin
            n_fail++; $display("FAIL basic_gap got gp=%h vp=%b rp=%b tp=%b ip=%0d gn=%h vn=%b", gp, vp, rp, tp, ip, gn, vn);
        end
        step();
        n_assert++;
        if ({rp, rn, vp} !== 3'b110) begin
            n_fail++; $display("FAIL basic_ready got rp=%b rn=%b vp=%b want 1/1/0", rp, rn, vp);
        end
    endtask

    task automatic test_req_drop();
        sel_vld = 1'b1; sel = 4'd3; req = 16'h0000;
        step();
        n_assert++;
        if ({gp, vp, rp, gn} !== {16'h0000, 1'b0, 1'b1, 16'hFFFF}) begin
            n_fail++; $display("FAIL noreq_ignored got gp=%h vp=%b rp=%b gn=%h", gp, vp, rp, gn);
        end
        req = 16'h0008;
        step();
        sel_vld = 1'b0;
        n_assert++;
        if ({gp, ip, gn, in_} !== {16'h0008, 4'd3, 16'hFFF7, 4'd3}) begin
            n_fail++; $display("FAIL drop_grant got gp=%h ip=%0d gn=%h in=%0d", gp, ip, gn, in_);
        end
        req = 16'h0000;
        step();
        n_assert++;
        if ({gp, vp, tp, gn, vn, tn} !== {16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL drop_gap got gp=%h vp=%b tp=%b gn=%h vn=%b tn=%b", gp, vp, tp, gn, vn, tn);
        end
        step();
    endtask

    task automatic test_timeout();
        sel_vld = 1'b1; sel = 4'd15; req = 16'h8000;
        step();
        sel_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_assert++;
            if ({gp, vp, tp} !== {16'h8000, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL hold_cycle%0d got gp=%h vp=%b tp=%b", k, gp, vp, tp);
            end
            step();
        end
        n_assert++;
        if ({gp, vp, tp, rp} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_gap got gp=%h vp=%b tp=%b rp=%b", gp, vp, tp, rp);
        end
        n_assert++;
        if ({gn, vn, tn} !== {16'h7FFF, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL nolimit_hold got gn=%h vn=%b tn=%b", gn, vn, tn);
        end
        step();
        n_assert++;
        if ({tp, rp, gn} !== {1'b0, 1'b1, 16'h7FFF}) begin
            n_fail++; $display("FAIL timeout_pulse_end got tp=%b rp=%b gn=%h", tp, rp, gn);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_assert++;
        if ({gn, vn, tn, rp, gp} !== {16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL idle_done got gn=%h vn=%b tn=%b rp=%b gp=%h", gn, vn, tn, rp, gp);
        end
        step();
    endtask

    task automatic test_done_at_limit();
        sel_vld = 1'b1; sel = 4'd15; req = 16'h8000;
        step();
        sel_vld = 1'b0;
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        n_assert++;
        if ({gp, vp, tp, gn, tn} !== {16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0}) begin
            n_fail++; $display("FAIL done_at_limit got gp=%h vp=%b tp=%b gn=%h tn=%b", gp, vp, tp, gn, tn);
        end
        step();
    endtask

    task automatic test_back_to_back();
        sel_vld = 1'b1; sel = 4'd2; req = 16'h0084;
        step();
        sel = 4'd7;
        n_assert++;
        if ({gp, ip} !== {16'h0004, 4'd2}) begin
            n_fail++; $display("FAIL b2b_first got gp=%h ip=%0d", gp, ip);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_assert++;
        if ({gp, rp, vp, ip} !== {16'h0000, 1'b0, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL b2b_gap got gp=%h rp=%b vp=%b ip=%0d", gp, rp, vp, ip);
        end
        step();
        n_assert++;
        if ({gp, rp, vp} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL b2b_idle got gp=%h rp=%b vp=%b", gp, rp, vp);
        end
        step();
        sel_vld = 1'b0;
        n_assert++;
        if ({gp, ip, vp, gn} !== {16'h0080, 4'd7, 1'b1, 16'hFF7F}) begin
            n_fail++; $display("FAIL b2b_second got gp=%h ip=%0d vp=%b gn=%h", gp, ip, vp, gn);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        sel_vld = 1'b1; sel = 4'd5; req = 16'h0020;
        step();
        sel_vld = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_assert++;
        if ({gp, vp, ip, tp, rp} !== {16'h0000, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_p got %h/%b/%0d/%b/%b", gp, vp, ip, tp, rp);
        end
        n_assert++;
        if ({gn, vn, in_, tn, rn} !== {16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_n got %h/%b/%0d/%b/%b", gn, vn, in_, tn, rn);
        end
        step();
        n_assert++;
        if ({rp, rn, tp} !== 3'b110) begin
            n_fail++; $display("FAIL rst_release got rp=%b rn=%b tp=%b", rp, rn, tp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req_drop();
        test_timeout();
        test_done_at_limit();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
